// File: rtl/pkt_read_arbiter_pkg.sv
// Shared types and widths for the packet read arbiter slice.
package pkt_read_arbiter_pkg;

  localparam int unsigned PKT_DATA_W = 134;
  localparam int unsigned PKT_ADDR_W = 16;

  // Flit type lives in the top two bits of every 134-bit flit, [133:132].
  typedef enum logic [1:0] {
    FlitSingle = 2'b00,
    FlitHead   = 2'b01,
    FlitTail   = 2'b10,
    FlitBody   = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e                  flit_type;
    logic [PKT_DATA_W-3:0]       payload;
  } pkt_flit_t;

endpackage

// File: rtl/pkt_read_arbiter_if.sv
// Bundles the per-port read channels and the memory read channel of the arbiter.
interface pkt_read_arbiter_if
  import pkt_read_arbiter_pkg::*;
#(
  parameter int unsigned PORT_NUM = 8,
  parameter int unsigned TAG_AW   = 4
);

  logic [PORT_NUM*PKT_ADDR_W-1:0] iv_pkt_raddr;
  logic [PORT_NUM-1:0]            iv_pkt_rd;
  logic [PORT_NUM-1:0]            ov_pkt_raddr_ack;
  logic [PKT_ADDR_W-1:0]          ov_mem_raddr;
  logic                           o_mem_rd;
  logic                           i_mem_raddr_ack;
  logic [PKT_DATA_W-1:0]          iv_mem_data;
  logic                           i_mem_data_wr;
  logic [PKT_DATA_W-1:0]          ov_pkt_data;
  logic [PORT_NUM-1:0]            ov_pkt_data_wr;
  logic [TAG_AW:0]                ov_inflight_cnt;
  logic                           o_tag_err_pulse;

  // Arbiter side.
  modport master (
    input  iv_pkt_raddr, iv_pkt_rd, i_mem_raddr_ack, iv_mem_data, i_mem_data_wr,
    output ov_pkt_raddr_ack, ov_mem_raddr, o_mem_rd, ov_pkt_data, ov_pkt_data_wr,
           ov_inflight_cnt, o_tag_err_pulse
  );

  // Requester / memory side.
  modport slave (
    output iv_pkt_raddr, iv_pkt_rd, i_mem_raddr_ack, iv_mem_data, i_mem_data_wr,
    input  ov_pkt_raddr_ack, ov_mem_raddr, o_mem_rd, ov_pkt_data, ov_pkt_data_wr,
           ov_inflight_cnt, o_tag_err_pulse
  );

endinterface

// File: rtl/pkt_read_tag_fifo.sv
// In-order FIFO of requesting port ids, one entry per outstanding memory read.
module pkt_read_tag_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // Pop on empty is dropped even if a push lands in the same cycle (no bypass).
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d  = wptr_q + AW'(push_ok);
    rptr_d  = rptr_q + AW'(pop_ok);
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/pkt_read_arbiter.sv
// Round-robin share of the packet memory read port, with in-order routing of returned data.
module pkt_read_arbiter
  import pkt_read_arbiter_pkg::*;
#(
  parameter int unsigned PORT_NUM  = 8,
  parameter int unsigned PID_W     = 3,
  parameter int unsigned TAG_DEPTH = 16,
  parameter int unsigned TAG_AW    = 4
) (
  input logic                i_clk,
  input logic                i_rst,
  pkt_read_arbiter_if.master bus
);

  logic [PKT_ADDR_W-1:0] port_addr [PORT_NUM];

  logic [PID_W-1:0]      last_grant_q, last_grant_d;
  logic [PID_W-1:0]      grant_id;
  logic                  grant_vld, grant_en, grant;

  logic                  mem_rd_q, mem_rd_d;
  logic [PKT_ADDR_W-1:0] mem_raddr_q, mem_raddr_d;

  pkt_flit_t             pkt_data_q, pkt_data_d;
  logic [PORT_NUM-1:0]   pkt_data_wr_q, pkt_data_wr_d;
  logic                  tag_err_q, tag_err_d;

  logic                  tag_full, tag_empty, tag_pop;
  logic [TAG_AW:0]       tag_count;
  logic [PID_W-1:0]      tag_head;

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_addr
    assign port_addr[p] = bus.iv_pkt_raddr[p*PKT_ADDR_W +: PKT_ADDR_W];
  end

  // Priority search starting one past the last granted port, wrapping.
  always_comb begin
    logic [PID_W-1:0] idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = last_grant_q;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      idx = (idx == PID_W'(PORT_NUM - 1)) ? '0 : idx + 1'b1;
      if (!grant_vld && bus.iv_pkt_rd[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  // A new read may issue when the memory slot is free or draining, and a tag slot exists.
  assign grant_en = (!mem_rd_q || bus.i_mem_raddr_ack) && !tag_full;
  assign grant    = grant_en && grant_vld;
  assign tag_pop  = bus.i_mem_data_wr && !tag_empty;

  // Same-cycle one-hot accept to the winning requester.
  always_comb begin
    bus.ov_pkt_raddr_ack = '0;
    if (grant) begin
      bus.ov_pkt_raddr_ack[grant_id] = 1'b1;
    end
  end

  // Memory read channel next-state; holds under memory backpressure.
  always_comb begin
    mem_rd_d     = mem_rd_q;
    mem_raddr_d  = mem_raddr_q;
    last_grant_d = last_grant_q;
    if (grant) begin
      mem_rd_d     = 1'b1;
      mem_raddr_d  = port_addr[grant_id];
      last_grant_d = grant_id;
    end else if (bus.i_mem_raddr_ack) begin
      mem_rd_d = 1'b0;
    end
  end

  // Return path next-state: route to head tag, or flag a return with nothing outstanding.
  always_comb begin
    pkt_data_d    = pkt_data_q;
    pkt_data_wr_d = '0;
    tag_err_d     = 1'b0;
    if (bus.i_mem_data_wr) begin
      if (!tag_empty) begin
        pkt_data_d              = pkt_flit_t'(bus.iv_mem_data);
        pkt_data_wr_d[tag_head] = 1'b1;
      end else begin
        tag_err_d = 1'b1;
      end
    end
  end

  // Output and arbitration registers; reset leaves port 0 with highest priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant_q  <= PID_W'(PORT_NUM - 1);
      mem_rd_q      <= 1'b0;
      mem_raddr_q   <= '0;
      pkt_data_q    <= '0;
      pkt_data_wr_q <= '0;
      tag_err_q     <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      mem_rd_q      <= mem_rd_d;
      mem_raddr_q   <= mem_raddr_d;
      pkt_data_q    <= pkt_data_d;
      pkt_data_wr_q <= pkt_data_wr_d;
      tag_err_q     <= tag_err_d;
    end
  end

  pkt_read_tag_fifo #(
    .WIDTH (PID_W),
    .DEPTH (TAG_DEPTH),
    .AW    (TAG_AW)
  ) u_tag_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (grant),
    .pop_i   (tag_pop),
    .din_i   (grant_id),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count),
    .head_o  (tag_head)
  );

  assign bus.o_mem_rd        = mem_rd_q;
  assign bus.ov_mem_raddr    = mem_raddr_q;
  assign bus.ov_pkt_data     = pkt_data_q;
  assign bus.ov_pkt_data_wr  = pkt_data_wr_q;
  assign bus.o_tag_err_pulse = tag_err_q;
  assign bus.ov_inflight_cnt = tag_count;

endmodule
